// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read slave (AR + R) between NUM_MST read masters.
// One burst in flight at a time; R beats are routed back to the owner until the burst ends.
//
// state  | meaning
// IDLE   | no owner; searching m_arvalid round-robin from ptr
// ADDR   | owner granted; presenting its AR to the slave
// DATA   | AR accepted; routing R beats to the owner until burst end
module axi_rd_arbiter #(
   parameter int NUM_MST = 2,
   parameter int IDW     = 4,
   parameter int AW      = 32,
   parameter int DW      = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MST-1:0]     m_arvalid,
   output logic [NUM_MST-1:0]     m_arready,
   input  logic [NUM_MST*IDW-1:0] m_arid,
   input  logic [NUM_MST*AW-1:0]  m_araddr,
   input  logic [NUM_MST*4-1:0]   m_arlen,
   input  logic [NUM_MST*3-1:0]   m_arsize,
   input  logic [NUM_MST*2-1:0]   m_arburst,
   output logic [NUM_MST-1:0]     m_rvalid,
   input  logic [NUM_MST-1:0]     m_rready,
   output logic [DW-1:0]          m_rdata,
   output logic [IDW-1:0]         m_rid,
   output logic [1:0]             m_rresp,
   output logic                   m_rlast,
   output logic                   s_arvalid,
   input  logic                   s_arready,
   output logic [IDW-1:0]         s_arid,
   output logic [AW-1:0]          s_araddr,
   output logic [3:0]             s_arlen,
   output logic [2:0]             s_arsize,
   output logic [1:0]             s_arburst,
   input  logic                   s_rvalid,
   output logic                   s_rready,
   input  logic [DW-1:0]          s_rdata,
   input  logic [IDW-1:0]         s_rid,
   input  logic [1:0]             s_rresp,
   input  logic                   s_rlast,
   output logic [NUM_MST-1:0]     gnt,
   output logic                   err_len,
   output logic                   err_id
);

   localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_MST-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]       arid_q, arid_d;
   logic [3:0]           arlen_q, arlen_d;
   logic [4:0]           beat_cnt_q, beat_cnt_d;

   logic                 hit;
   logic [PW-1:0]        hit_idx;
   int                   idx;
   logic [PW-1:0]        ptr_nxt;
   logic                 r_hs;
   logic                 last_cnt;
   logic                 burst_end;

   // First requester at or after ptr, wrapping modulo NUM_MST.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_MST; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_MST) idx = idx - NUM_MST;
         if (!hit && m_arvalid[idx]) begin
            hit     = 1'b1;
            hit_idx = PW'(idx);
         end
      end
   end

   always_comb begin
      s_arid    = '0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arburst = '0;
      ptr_nxt   = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (gnt_q[i]) begin
            s_arid    = m_arid[i*IDW +: IDW];
            s_araddr  = m_araddr[i*AW +: AW];
            s_arlen   = m_arlen[i*4 +: 4];
            s_arsize  = m_arsize[i*3 +: 3];
            s_arburst = m_arburst[i*2 +: 2];
            ptr_nxt   = (i == NUM_MST-1) ? '0 : PW'(i+1);
         end
      end
   end

   assign s_arvalid = (state_q == S_ADDR);
   assign m_arready = (state_q == S_ADDR && s_arready) ? gnt_q : '0;
   assign m_rvalid  = (state_q == S_DATA && s_rvalid) ? gnt_q : '0;
   assign s_rready  = (state_q == S_DATA) && |(gnt_q & m_rready);

   assign m_rdata = s_rdata;
   assign m_rid   = s_rid;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;
   assign gnt     = gnt_q;

   // beat_cnt counts completed beats, so the expected last beat is at beat_cnt == arlen.
   assign r_hs      = s_rvalid && s_rready;
   assign last_cnt  = (beat_cnt_q == {1'b0, arlen_q});
   assign burst_end = r_hs && (s_rlast || last_cnt);
   assign err_len   = burst_end && (s_rlast ^ last_cnt);
   assign err_id    = r_hs && (s_rid != arid_q);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      arid_d     = arid_q;
      arlen_d    = arlen_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               gnt_d          = '0;
               gnt_d[hit_idx] = 1'b1;
               for (int i = 0; i < NUM_MST; i++) begin
                  if (hit_idx == PW'(i)) begin
                     arid_d  = m_arid[i*IDW +: IDW];
                     arlen_d = m_arlen[i*4 +: 4];
                  end
               end
               beat_cnt_d = '0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (s_arready) begin
               state_d = S_DATA;
               ptr_d   = ptr_nxt;
            end
         end
         S_DATA: begin
            if (r_hs) begin
               beat_cnt_d = beat_cnt_q + 5'd1;
               if (burst_end) begin
                  state_d = S_IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         arid_q     <= '0;
         arlen_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         arid_q     <= arid_d;
         arlen_q    <= arlen_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a randomized run
// checked against a burst-level round-robin reference model.
module tb_axi_rd_arbiter;

   localparam int N   = 3;
   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
   logic [N*IDW-1:0] m_arid;
   logic [N*AW-1:0]  m_araddr;
   logic [N*4-1:0]   m_arlen;
   logic [N*3-1:0]   m_arsize;
   logic [N*2-1:0]   m_arburst;
   logic [DW-1:0]    m_rdata, s_rdata;
   logic [IDW-1:0]   m_rid, s_rid, s_arid;
   logic [1:0]       m_rresp, s_rresp, s_arburst;
   logic             m_rlast, s_rlast, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AW-1:0]    s_araddr;
   logic [3:0]       s_arlen;
   logic [2:0]       s_arsize;
   logic [N-1:0]     gnt;
   logic             err_len, err_id;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.NUM_MST(N), .IDW(IDW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .gnt(gnt), .err_len(err_len), .err_id(err_id)
   );

   task automatic clear_inputs();
      m_arvalid = '0; m_rready = '0; m_arid = '0; m_araddr = '0;
      m_arlen = '0; m_arsize = '0; m_arburst = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rid = '0;
      s_rresp = '0; s_rlast = 1'b0;
   endtask

   task automatic set_ar(input int i, input logic [IDW-1:0] id,
                         input logic [AW-1:0] addr, input logic [3:0] len);
      m_arid[i*IDW +: IDW]  = id;
      m_araddr[i*AW +: AW]  = addr;
      m_arlen[i*4 +: 4]     = len;
      m_arsize[i*3 +: 3]    = 3'd3;
      m_arburst[i*2 +: 2]   = 2'd1;
   endtask

   // Leaves the bench at posedge+1 with rst released and the DUT idle.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Waits (bounded) for s_arvalid; returns at the negedge where it was seen.
   task automatic wait_ar(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_arvalid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      m_arvalid = '1;
      s_rvalid  = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || s_arvalid !== 1'b0 || s_rready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b s_arvalid=%b s_rready=%b, required 0/0/0", gnt, s_arvalid, s_rready);
      end
      n_checks++;
      if (m_arready !== '0 || m_rvalid !== '0 || err_len !== 1'b0 || err_id !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshakes: m_arready=%b m_rvalid=%b err_len=%b err_id=%b, required all 0",
                  m_arready, m_rvalid, err_len, err_id);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single();
      do_reset();
      set_ar(0, 4'h3, 32'h0000_1000, 4'd3);
      m_arvalid = 3'b001;
      m_rready  = '1;
      @(negedge clk);
      n_checks++;
      if (s_arvalid !== 1'b0 || gnt !== '0) begin
         n_fail++;
         $display("FAIL single_req_cycle: s_arvalid=%b gnt=%b, required 0 and 000", s_arvalid, gnt);
      end
      @(posedge clk); #1;
      s_arready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_1000 || s_arlen !== 4'd3 || s_arid !== 4'h3
          || gnt !== 3'b001 || m_arready !== 3'b001) begin
         n_fail++;
         $display("FAIL single_addr: arvalid=%b addr=%h len=%0d id=%0d gnt=%b arready=%b, required 1 00001000 3 3 001 001",
                  s_arvalid, s_araddr, s_arlen, s_arid, gnt, m_arready);
      end
      @(posedge clk); #1;
      m_arvalid = '0;
      s_arready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         s_rvalid = 1'b1;
         s_rdata  = DW'(b);
         s_rid    = 4'h3;
         s_rlast  = (b == 3);
         @(negedge clk);
         n_checks++;
         if (m_rvalid !== 3'b001 || m_rdata !== DW'(b) || m_rlast !== (b == 3) || err_len || err_id) begin
            n_fail++;
            $display("FAIL single_beat%0d: m_rvalid=%b data=%0d rlast=%b errs=%b%b, required 001 %0d %b 00",
                     b, m_rvalid, m_rdata, m_rlast, err_len, err_id, b, (b == 3));
         end
         @(posedge clk); #1;
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (gnt !== '0) begin
         n_fail++;
         $display("FAIL single_release: gnt=%b, required 000", gnt);
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_fairness();
      logic [N-1:0] pending;
      logic [N-1:0] oh;
      int last, nb, expi;
      do_reset();
      set_ar(0, 4'h1, 32'h100, 4'd0);
      set_ar(1, 4'h2, 32'h200, 4'd0);
      pending   = 3'b011;
      m_arvalid = pending;
      m_rready  = '1;
      s_arready = 1'b1;
      s_rvalid  = 1'b1;
      s_rlast   = 1'b1;
      last = N - 1;
      nb   = 0;
      for (int c = 0; c < 60 && nb < 4; c++) begin
         @(negedge clk);
         if (s_arvalid) begin
            expi = -1;
            for (int k = 1; k <= N; k++)
               if (expi < 0 && pending[(last + k) % N]) expi = (last + k) % N;
            oh = '0;
            oh[expi] = 1'b1;
            n_checks++;
            if (gnt !== oh || m_arready !== oh || m_rvalid !== '0) begin
               n_fail++;
               $display("FAIL fair_grant%0d: gnt=%b arready=%b rvalid=%b, required %b %b 000",
                        nb, gnt, m_arready, m_rvalid, oh, oh);
            end
            last  = expi;
            s_rid = s_arid;
            nb++;
         end
         if (m_rvalid !== '0) begin
            n_checks++;
            if (err_id || err_len) begin
               n_fail++;
               $display("FAIL fair_errs: err_len=%b err_id=%b, required 0 0", err_len, err_id);
            end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (nb < 4) begin
         n_fail++;
         $display("FAIL fair_timeout: bursts=%0d, required 4", nb);
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      bit ok;
      bit drop;
      logic [DW-1:0] got[$];
      int b;
      do_reset();
      set_ar(1, 4'h4, 32'h2000, 4'd7);
      m_arvalid = 3'b010;
      m_rready  = '1;
      wait_ar(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_ar_timeout: s_arvalid=%b, required 1", s_arvalid);
      end
      s_arready = 1'b1;
      @(posedge clk); #1;
      m_arvalid = '0;
      s_arready = 1'b0;
      b = 0;
      for (int c = 0; c < 40 && b < 8; c++) begin
         drop        = (c >= 2 && c <= 4);
         m_rready[1] = !drop;
         s_rvalid    = 1'b1;
         s_rdata     = DW'(b);
         s_rlast     = (b == 7);
         s_rid       = 4'h4;
         @(negedge clk);
         n_checks++;
         if (s_rready !== !drop || m_rvalid !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: s_rready=%b m_rvalid=%b, required %b 010", c, s_rready, m_rvalid, !drop);
         end
         if (s_rready) begin
            got.push_back(m_rdata);
            b++;
         end
         @(posedge clk); #1;
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      n_checks++;
      if (got.size() != 8) begin
         n_fail++;
         $display("FAIL bp_count: beats=%0d, required 8", got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
         n_checks++;
         if (got[k] !== DW'(k)) begin
            n_fail++;
            $display("FAIL bp_data%0d: got %0d, required %0d", k, got[k], k);
         end
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== '0) begin
         n_fail++;
         $display("FAIL bp_release: gnt=%b, required 000", gnt);
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_len_err();
      bit ok;
      // Early RLAST (ARLEN=1, RLAST on beat 0), then missing RLAST (ARLEN=0, no RLAST).
      for (int t = 0; t < 2; t++) begin
         do_reset();
         set_ar(0, 4'h2, 32'h3000, (t == 0) ? 4'd1 : 4'd0);
         m_arvalid = 3'b001;
         m_rready  = '1;
         wait_ar(ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL len_ar_timeout%0d: s_arvalid=%b, required 1", t, s_arvalid);
         end
         s_arready = 1'b1;
         @(posedge clk); #1;
         m_arvalid = '0;
         s_arready = 1'b0;
         s_rvalid  = 1'b1;
         s_rdata   = '0;
         s_rid     = 4'h2;
         s_rlast   = (t == 0);
         @(negedge clk);
         n_checks++;
         if (err_len !== 1'b1 || err_id !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_pulse%0d: err_len=%b err_id=%b, required 1 0", t, err_len, err_id);
         end
         @(posedge clk); #1;
         s_rvalid = 1'b0;
         s_rlast  = 1'b0;
         @(negedge clk);
         n_checks++;
         if (gnt !== '0 || s_arvalid !== 1'b0 || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_idle%0d: gnt=%b s_arvalid=%b err_len=%b, required 000 0 0",
                     t, gnt, s_arvalid, err_len);
         end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_id_err();
      bit ok;
      do_reset();
      set_ar(0, 4'h5, 32'h4000, 4'd1);
      m_arvalid = 3'b001;
      m_rready  = '1;
      wait_ar(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL id_ar_timeout: s_arvalid=%b, required 1", s_arvalid);
      end
      s_arready = 1'b1;
      @(posedge clk); #1;
      m_arvalid = '0;
      s_arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         s_rvalid = 1'b1;
         s_rdata  = DW'(b + 16);
         s_rid    = 4'h6;
         s_rlast  = (b == 1);
         @(negedge clk);
         n_checks++;
         if (err_id !== 1'b1 || err_len !== 1'b0 || m_rvalid !== 3'b001 || m_rdata !== DW'(b + 16)
             || m_rid !== 4'h6) begin
            n_fail++;
            $display("FAIL id_err_beat%0d: err_id=%b err_len=%b m_rvalid=%b data=%0d rid=%0d, required 1 0 001 %0d 6",
                     b, err_id, err_len, m_rvalid, m_rdata, m_rid, b + 16);
         end
         @(posedge clk); #1;
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || err_id !== 1'b0) begin
         n_fail++;
         $display("FAIL id_err_release: gnt=%b err_id=%b, required 000 0", gnt, err_id);
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      set_ar(2, 4'h7, 32'h5000, 4'd5);
      m_arvalid = 3'b100;
      m_rready  = '1;
      wait_ar(ok);
      s_arready = 1'b1;
      @(posedge clk); #1;
      m_arvalid = '0;
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rid     = 4'h7;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (!ok || gnt !== 3'b100 || s_rready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_in_data: ar_seen=%b gnt=%b s_rready=%b, required 1 100 1", ok, gnt, s_rready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || s_arvalid !== 1'b0 || s_rready !== 1'b0 || m_rvalid !== '0) begin
         n_fail++;
         $display("FAIL rstmid_idle: gnt=%b s_arvalid=%b s_rready=%b m_rvalid=%b, required 000 0 0 000",
                  gnt, s_arvalid, s_rready, m_rvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_random();
      logic [N-1:0] pend, cur_pend, prev_pend, oh, exp_rv;
      logic         prev_sarv;
      logic [IDW-1:0] slave_id;
      int last, owner, rem, done, expi;
      do_reset();
      pend = '0; prev_pend = '0; prev_sarv = 1'b0;
      last = N - 1; owner = 0; rem = 0; done = 0; slave_id = '0;
      for (int c = 0; c < 4000 && done < 30; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               set_ar(i, IDW'($urandom), AW'($urandom), 4'($urandom_range(0, 7)));
            end
         end
         cur_pend  = pend;
         m_arvalid = pend;
         m_rready  = N'($urandom);
         s_arready = 1'($urandom_range(0, 1));
         if (rem > 0) begin
            s_rvalid = ($urandom_range(0, 3) != 0);
            s_rdata  = {32'($urandom), 32'(c)};
            s_rid    = slave_id;
            s_rlast  = (rem == 1);
         end else begin
            s_rvalid = 1'($urandom_range(0, 1));
            s_rdata  = {32'($urandom), 32'($urandom)};
            s_rid    = IDW'($urandom);
            s_rlast  = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (rem > 0) begin
            oh = '0;
            oh[owner] = 1'b1;
            exp_rv = s_rvalid ? oh : '0;
            n_checks++;
            if (m_rvalid !== exp_rv || s_rready !== m_rready[owner] || m_rdata !== s_rdata) begin
               n_fail++;
               $display("FAIL rnd_route c%0d: m_rvalid=%b s_rready=%b, required %b %b (owner %0d)",
                        c, m_rvalid, s_rready, exp_rv, m_rready[owner], owner);
            end
            if (s_rvalid && m_rready[owner]) begin
               n_checks++;
               if (err_id || err_len) begin
                  n_fail++;
                  $display("FAIL rnd_errs c%0d: err_len=%b err_id=%b, required 0 0", c, err_len, err_id);
               end
               rem--;
               if (rem == 0) done++;
            end
         end else begin
            n_checks++;
            if (m_rvalid !== '0 || s_rready !== 1'b0 || err_id || err_len) begin
               n_fail++;
               $display("FAIL rnd_quiet c%0d: m_rvalid=%b s_rready=%b errs=%b%b, required 000 0 00",
                        c, m_rvalid, s_rready, err_len, err_id);
            end
         end
         if (s_arvalid && !prev_sarv) begin
            expi = 0;
            for (int k = N; k >= 1; k--)
               if (prev_pend[(last + k) % N]) expi = (last + k) % N;
            oh = '0;
            oh[expi] = 1'b1;
            n_checks++;
            if (gnt !== oh || s_araddr !== m_araddr[expi*AW +: AW] || s_arlen !== m_arlen[expi*4 +: 4]) begin
               n_fail++;
               $display("FAIL rnd_grant c%0d: gnt=%b addr=%h len=%0d, required %b %h %0d",
                        c, gnt, s_araddr, s_arlen, oh, m_araddr[expi*AW +: AW], m_arlen[expi*4 +: 4]);
            end
            owner = expi;
         end
         if (s_arvalid && s_arready) begin
            pend[owner] = 1'b0;
            last        = owner;
            rem         = int'(m_arlen[owner*4 +: 4]) + 1;
            slave_id    = m_arid[owner*IDW +: IDW];
         end
         prev_sarv = s_arvalid;
         prev_pend = cur_pend;
         @(posedge clk); #1;
      end
      n_checks++;
      if (done < 30) begin
         n_fail++;
         $display("FAIL rnd_timeout: bursts=%0d, required 30", done);
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_len_err();
      test_id_err();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
